// File: rtl/phoenix_memory_pkg.sv
// Shared types and helpers for the phoeniX memory subsystem: port FSM states,
// access direction encoding, out-of-range fill word and byte-lane expansion.
package phoenix_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  localparam logic        MEM_READ  = 1'b0;
  localparam logic        MEM_WRITE = 1'b1;
  localparam logic [31:0] DEADBEEF  = 32'hDEAD_BEEF;

  // frame_mask[3] enables bits 7:0 and frame_mask[0] enables bits 31:24.
  function automatic logic [31:0] lane_mask(input logic [3:0] frame_mask);
    return {{8{frame_mask[0]}}, {8{frame_mask[1]}}, {8{frame_mask[2]}}, {8{frame_mask[3]}}};
  endfunction

endpackage

// File: rtl/phoenix_memory_if.sv
// Core-side instruction and data bus of the phoeniX memory subsystem.
// The core drives the master modport, the memory implements the slave modport.
interface phoenix_memory_if;
  logic        imem_enable;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        dmem_enable;
  logic        dmem_state;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_frame_mask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output imem_enable, imem_address,
    input  imem_data, imem_ready,
    output dmem_enable, dmem_state, dmem_address, dmem_frame_mask, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_enable, imem_address,
    output imem_data, imem_ready,
    input  dmem_enable, dmem_state, dmem_address, dmem_frame_mask, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/phoenix_mem_port_ctrl.sv
// Per-port request sequencer with latency counter; one instance serves imem, one dmem.
//   state | meaning
//   IDLE  | waiting for enable; the request is accepted on the edge it is seen
//   WAIT  | counting up to target; hold keeps the port here once target is reached
//   RESP  | ready high for exactly one cycle, then back to IDLE
module phoenix_mem_port_ctrl
  import phoenix_memory_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] target,
  input  logic          hold,
  output logic          accept,
  output logic          ready
);

  port_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == target) begin
          if (!hold) state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/phoenix_memory_subsystem.sv
// phoeniX dual-port memory: read-only imem port, masked read/write dmem port, console TX FIFO
// and halt register. Define PHOENIX_MEM_BOUNDS_CHECK_EN to trap out-of-range array accesses.
module phoenix_memory_subsystem
  import phoenix_memory_pkg::*;
#(
  parameter int unsigned MEM_WORDS          = 8*1024*1024,
  parameter int unsigned READ_LATENCY       = 1,
  parameter logic [31:0] CONSOLE_ADDRESS    = 32'h1000_0000,
  parameter logic [31:0] HALT_ADDRESS       = 32'h1000_0004,
  parameter int unsigned CONSOLE_FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  phoenix_memory_if.slave bus,
  output logic            console_valid,
  output logic [7:0]      console_char,
  input  logic            console_ready,
  output logic            halt,
  output logic [31:0]     halt_code,
  output logic            bounds_error
);

  localparam int unsigned AW     = $clog2(MEM_WORDS);
  localparam int unsigned PW     = $clog2(CONSOLE_FIFO_DEPTH) + 1;
  localparam logic [3:0]  RD_LAT = 4'(READ_LATENCY);

  function automatic logic [AW-1:0] word_idx(input logic [29:0] w);
    return AW'({2'b00, w} % MEM_WORDS);
  endfunction

  logic [31:0]   mem [MEM_WORDS];
  logic [7:0]    fifo_mem [CONSOLE_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, fifo_count;
  logic          fifo_full, fifo_push, fifo_pop;

  logic          i_accept, i_ready, d_accept, d_ready, d_hold;
  logic [3:0]    d_target;
  logic [31:0]   i_rdata_q, d_rdata_q, d_rdata_d, lane;
  logic          d_write, d_console, d_halt, d_mmio, i_oob, d_oob;
  logic          d_write_q, con_pend_q;
  logic [7:0]    con_char_q;
  logic [AW-1:0] i_idx, d_idx;
  logic          addr_lsb_unused;

  assign addr_lsb_unused = ^{bus.imem_address[1:0], bus.dmem_address[1:0]};
  assign i_idx     = word_idx(bus.imem_address[31:2]);
  assign d_idx     = word_idx(bus.dmem_address[31:2]);
  assign d_write   = (bus.dmem_state == MEM_WRITE);
  assign d_console = (bus.dmem_address[31:2] == CONSOLE_ADDRESS[31:2]);
  assign d_halt    = (bus.dmem_address[31:2] == HALT_ADDRESS[31:2]);
  assign d_mmio    = d_console || d_halt;
  assign lane      = lane_mask(bus.dmem_frame_mask);

`ifdef PHOENIX_MEM_BOUNDS_CHECK_EN
  function automatic logic in_bounds(input logic [29:0] w);
    return ({2'b00, w} < MEM_WORDS);
  endfunction

  assign i_oob = !in_bounds(bus.imem_address[31:2]);
  assign d_oob = !d_mmio && !in_bounds(bus.dmem_address[31:2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         bounds_error <= 1'b0;
    else if ((i_accept && i_oob) || (d_accept && d_oob)) bounds_error <= 1'b1;
  end
`else
  assign i_oob        = 1'b0;
  assign d_oob        = 1'b0;
  assign bounds_error = 1'b0;
`endif

  // Writes complete like a latency-1 read; a console push blocked by a full FIFO holds WAIT.
  assign d_target = d_write_q ? 4'd1 : RD_LAT;
  assign d_hold   = con_pend_q && !fifo_push;

  phoenix_mem_port_ctrl u_imem_ctrl (
    .clk(clk), .reset(reset), .enable(bus.imem_enable), .target(RD_LAT), .hold(1'b0),
    .accept(i_accept), .ready(i_ready)
  );

  phoenix_mem_port_ctrl u_dmem_ctrl (
    .clk(clk), .reset(reset), .enable(bus.dmem_enable), .target(d_target), .hold(d_hold),
    .accept(d_accept), .ready(d_ready)
  );

  assign fifo_count    = wr_ptr_q - rd_ptr_q;
  assign fifo_full     = (fifo_count == PW'(CONSOLE_FIFO_DEPTH));
  assign console_valid = (wr_ptr_q != rd_ptr_q);
  assign console_char  = console_valid ? fifo_mem[rd_ptr_q[PW-2:0]] : 8'h00;
  assign fifo_pop      = console_valid && console_ready;
  assign fifo_push     = con_pend_q && (!fifo_full || fifo_pop);

  always_comb begin
    d_rdata_d = mem[d_idx];
    if (d_console)  d_rdata_d = 32'(fifo_count);
    else if (d_halt) d_rdata_d = {31'b0, halt};
    else if (d_oob)  d_rdata_d = DEADBEEF;
  end

  // Array reads and writes share the acceptance edge, so a same-edge imem read sees the old word.
  always_ff @(posedge clk) begin
    if (d_accept && d_write && !d_mmio && !d_oob)
      mem[d_idx] <= (mem[d_idx] & ~lane) | (bus.dmem_wdata & lane);
    if (fifo_push) fifo_mem[wr_ptr_q[PW-2:0]] <= con_char_q;
    if (i_accept)  i_rdata_q <= i_oob ? DEADBEEF : mem[i_idx];
    if (d_accept)  d_rdata_q <= d_rdata_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      d_write_q  <= 1'b0;
      con_pend_q <= 1'b0;
      con_char_q <= 8'h00;
      halt       <= 1'b0;
      halt_code  <= 32'h0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (d_accept) begin
        d_write_q  <= d_write;
        con_pend_q <= d_write && d_console;
        con_char_q <= bus.dmem_wdata[7:0];
      end else if (fifo_push) begin
        con_pend_q <= 1'b0;
      end
      if (d_accept && d_write && d_halt && !halt) begin
        halt      <= 1'b1;
        halt_code <= bus.dmem_wdata;
      end
    end
  end

  assign bus.imem_ready = i_ready;
  assign bus.imem_data  = i_ready ? i_rdata_q : 32'h0;
  assign bus.dmem_ready = d_ready;
  assign bus.dmem_rdata = d_ready ? d_rdata_q : 32'h0;

endmodule

// File: tb/tb_phoenix_memory_subsystem.sv
// Self-checking bench for phoenix_memory_subsystem: directed scenarios plus randomized
// imem/dmem traffic compared against a word-array reference model.
module tb_phoenix_memory_subsystem;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned RL        = 3;
  localparam logic [31:0] CON_ADDR  = 32'h1000_0000;
  localparam logic [31:0] HALT_ADDR = 32'h1000_0004;
`ifdef PHOENIX_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        console_valid, console_ready, halt, bounds_error;
  logic [7:0]  console_char;
  logic [31:0] halt_code;

  always #5 clk = ~clk;

  phoenix_memory_if bus ();

  phoenix_memory_subsystem #(
    .MEM_WORDS(MEM_WORDS), .READ_LATENCY(RL), .CONSOLE_ADDRESS(CON_ADDR),
    .HALT_ADDRESS(HALT_ADDR), .CONSOLE_FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .console_valid(console_valid), .console_char(console_char), .console_ready(console_ready),
    .halt(halt), .halt_code(halt_code), .bounds_error(bounds_error)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_mem [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_oob(input logic [31:0] a);
    return BOUNDS_EN && ((a >> 2) >= MEM_WORDS);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_oob(a)) return 32'hDEAD_BEEF;
    return ref_mem.exists(model_idx(a)) ? ref_mem[model_idx(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    if (model_oob(a)) return;
    w = model_read(a);
    for (int b = 0; b < 4; b++)
      if (m[3-b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[model_idx(a)] = w;
  endtask

  // lat counts clock edges from acceptance through the edge that raises ready.
  task automatic dmem_op(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    bus.dmem_enable     = 1'b1;
    bus.dmem_state      = wr;
    bus.dmem_address    = addr;
    bus.dmem_frame_mask = mask;
    bus.dmem_wdata      = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.dmem_ready && lat < 200);
    rdata = bus.dmem_rdata;
    bus.dmem_enable = 1'b0;
  endtask

  task automatic imem_op(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    bus.imem_enable  = 1'b1;
    bus.imem_address = addr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.imem_ready && lat < 200);
    rdata = bus.imem_data;
    bus.imem_enable = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned w;
    w = $urandom_range(0, 31) + MEM_WORDS * $urandom_range(0, 2);
    return {w[29:0], 2'(($urandom_range(0, 3)))};
  endfunction

  logic [31:0] rd, ird, v, ia, da, exp_i, exp_d;
  int          lat, ilat;
  logic        d_done, dwr;
  logic [3:0]  dm;
  logic [7:0]  drained [$];

  initial begin
    bus.imem_enable = 1'b0; bus.imem_address = '0;
    bus.dmem_enable = 1'b0; bus.dmem_state = 1'b0; bus.dmem_address = '0;
    bus.dmem_frame_mask = '0; bus.dmem_wdata = '0;
    console_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_imem_ready", bus.imem_ready, 0);
    chk("rst_dmem_ready", bus.dmem_ready, 0);
    chk("rst_imem_data", bus.imem_data, 0);
    chk("rst_dmem_rdata", bus.dmem_rdata, 0);
    chk("rst_console_valid", console_valid, 0);
    chk("rst_console_char", console_char, 0);
    chk("rst_halt", halt, 0);
    chk("rst_halt_code", halt_code, 0);
    chk("rst_bounds", bounds_error, 0);
    reset = 1'b1;

    for (int w = 0; w < 32; w++) begin
      v = $urandom;
      dmem_op(1'b1, 32'(w * 4), 4'hF, v, rd, lat);
      model_write(32'(w * 4), 4'hF, v);
    end

    // instruction fetch latency and data
    dmem_op(1'b1, 32'h40, 4'hF, 32'h0000_0513, rd, lat);
    model_write(32'h40, 4'hF, 32'h0000_0513);
    imem_op(32'h40, ird, ilat);
    chk("t1_imem_lat", ilat, RL + 1);
    chk("t1_imem_data", ird, 32'h0000_0513);

    // single-lane masked write
    dmem_op(1'b1, 32'h100, 4'hF, 32'h1122_3344, rd, lat);
    dmem_op(1'b1, 32'h100, 4'b1000, 32'hAABB_CCDD, rd, lat);
    chk("t2_write_lat", lat, 2);
    @(negedge clk);
    chk("t2_ready_pulse", bus.dmem_ready, 0);
    dmem_op(1'b0, 32'h100, 4'hF, 32'h0, rd, lat);
    chk("t2_read_lat", lat, RL + 1);
    chk("t2_masked_word", rd, 32'h1122_33DD);
    model_write(32'h100, 4'hF, 32'h1122_33DD);

    // same-edge collision, imem sees the old word
    dmem_op(1'b1, 32'h200, 4'hF, 32'h1234_5678, rd, lat);
    fork
      imem_op(32'h200, ird, ilat);
      dmem_op(1'b1, 32'h200, 4'hF, 32'hFFFF_FFFF, rd, lat);
    join
    chk("t3_imem_old", ird, 32'h1234_5678);
    imem_op(32'h200, ird, ilat);
    chk("t3_imem_new", ird, 32'hFFFF_FFFF);
    model_write(32'h200, 4'hF, 32'hFFFF_FFFF);

    // beyond the array: wrap, or trap when bounds checking is built in
    chk("t6_bounds_pre", bounds_error, 0);
    dmem_op(1'b0, 32'h1000, 4'hF, 32'h0, rd, lat);
    chk("t6_dmem_data", rd, model_read(32'h1000));
    chk("t6_dmem_lat", lat, RL + 1);
    chk("t6_bounds", bounds_error, 32'(BOUNDS_EN));
    imem_op(32'h1004, ird, ilat);
    chk("t6_imem_data", ird, model_read(32'h1004));

    for (int it = 0; it < 80; it++) begin
      ia  = rand_addr();
      da  = rand_addr();
      dwr = 1'($urandom_range(0, 1));
      dm  = 4'($urandom_range(0, 15));
      v   = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          exp_d = model_read(da);
          dmem_op(dwr, da, dm, v, rd, lat);
          chk("rnd_dmem_lat", lat, dwr ? 2 : RL + 1);
          if (dwr) model_write(da, dm, v);
          else     chk("rnd_dmem_data", rd, exp_d);
        end
        1: begin
          exp_i = model_read(ia);
          imem_op(ia, ird, ilat);
          chk("rnd_imem_lat", ilat, RL + 1);
          chk("rnd_imem_data", ird, exp_i);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) ia = da;
          exp_i = model_read(ia);
          exp_d = model_read(da);
          fork
            imem_op(ia, ird, ilat);
            dmem_op(dwr, da, dm, v, rd, lat);
          join
          chk("rnd_dual_imem_data", ird, exp_i);
          if (dwr) model_write(da, dm, v);
          else     chk("rnd_dual_dmem_data", rd, exp_d);
        end
      endcase
    end
    chk("rnd_bounds_sticky", bounds_error, 32'(BOUNDS_EN));

    // console FIFO fill, stall on full, release by one pop, ordered drain
    for (int i = 0; i < 16; i++) begin
      dmem_op(1'b1, CON_ADDR, 4'b1000, 32'(8'h41 + i), rd, lat);
      chk("con_push_lat", lat, 2);
    end
    dmem_op(1'b0, CON_ADDR, 4'hF, 32'h0, rd, lat);
    chk("con_count_full", rd, 16);
    chk("con_head_valid", console_valid, 1);
    d_done = 1'b0;
    fork
      begin
        dmem_op(1'b1, CON_ADDR, 4'b1000, 32'h0000_0051, rd, lat);
        d_done = 1'b1;
      end
      begin
        repeat (12) @(negedge clk);
        chk("con_stall_no_ready", d_done, 0);
        chk("con_head_A", console_char, 8'h41);
        console_ready = 1'b1;
        @(negedge clk);
        console_ready = 1'b0;
      end
    join
    chk("con_stall_released", lat < 200, 1);
    dmem_op(1'b0, CON_ADDR, 4'hF, 32'h0, rd, lat);
    chk("con_count_after_swap", rd, 16);
    console_ready = 1'b1;
    for (int c = 0; c < 60 && drained.size() < 16; c++) begin
      if (console_valid) drained.push_back(console_char);
      @(negedge clk);
    end
    console_ready = 1'b0;
    chk("con_drain_count", drained.size(), 16);
    foreach (drained[i]) chk($sformatf("con_drain_%0d", i), drained[i], 32'(8'h42 + i));
    chk("con_empty", console_valid, 0);

    // halt is sticky and keeps the first code
    chk("halt_pre", halt, 0);
    dmem_op(1'b1, HALT_ADDR, 4'hF, 32'h0000_0001, rd, lat);
    chk("halt_set", halt, 1);
    chk("halt_code_first", halt_code, 1);
    dmem_op(1'b1, HALT_ADDR, 4'hF, 32'h0000_0002, rd, lat);
    chk("halt_code_kept", halt_code, 1);

    // reset during an accepted write: no ready, but the word is committed
    @(negedge clk);
    bus.dmem_enable = 1'b1; bus.dmem_state = 1'b1; bus.dmem_address = 32'h8;
    bus.dmem_frame_mask = 4'hF; bus.dmem_wdata = 32'hC0FF_EE00;
    @(negedge clk);
    reset = 1'b0;
    bus.dmem_enable = 1'b0;
    #1;
    chk("rst_mid_no_ready", bus.dmem_ready, 0);
    chk("rst_mid_halt", halt, 0);
    chk("rst_mid_halt_code", halt_code, 0);
    chk("rst_mid_bounds", bounds_error, 0);
    repeat (2) @(negedge clk);
    chk("rst_mid_still_no_ready", bus.dmem_ready, 0);
    reset = 1'b1;
    model_write(32'h8, 4'hF, 32'hC0FF_EE00);
    dmem_op(1'b0, 32'h8, 4'hF, 32'h0, rd, lat);
    chk("rst_mid_word_kept", rd, model_read(32'h8));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
